// File: rtl/mem_stage_dport_if.sv
// rtl/mem_stage_dport_if.sv - EX/MEM request, data-cache and MEM/WB result bundle for the memory stage
interface mem_stage_dport_if;
    // EX/MEM pipeline register outputs
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        pipe_advance;

    // data-cache port
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    // results toward hazard logic and MEM/WB
    logic        stall;
    logic [31:0] load_data;
    logic        misaligned;

    // pipeline and cache side: drives requests and responses
    modport master (
        output req_valid, req_read, req_write, req_funct3, req_addr,
               req_wdata, req_wmask, pipe_advance, dmem_rdata, dmem_resp,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata,
               dmem_byte_enable, stall, load_data, misaligned
    );

    // memory-stage controller side
    modport slave (
        input  req_valid, req_read, req_write, req_funct3, req_addr,
               req_wdata, req_wmask, pipe_advance, dmem_rdata, dmem_resp,
        output dmem_read, dmem_write, dmem_address, dmem_wdata,
               dmem_byte_enable, stall, load_data, misaligned
    );
endinterface

// File: rtl/mem_stage_dport.sv
// rtl/mem_stage_dport.sv - memory-stage data-port controller: cache handshake, stall and load alignment
module mem_stage_dport (
    input  logic               clk,
    input  logic               rst,
    mem_stage_dport_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        capture;
    logic [31:0] data_q;

    logic        load_mis;
    logic        store_mis;
    logic        mis;
    logic        access;
    logic        issue;
    logic        in_done;
    logic        load_valid;
    logic [31:0] word;
    logic [31:0] shifted;
    logic [31:0] aligned;

    // natural-alignment check; loads by width, stores by byte-mask shape
    always_comb begin
        load_mis  = 1'b0;
        store_mis = 1'b1;
        case (bus.req_funct3)
            3'b010:         load_mis = (bus.req_addr[1:0] != 2'b00);
            3'b001, 3'b101: load_mis = bus.req_addr[0];
            default:        load_mis = 1'b0;
        endcase
        case (bus.req_wmask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: store_mis = 1'b0;
            default:                   store_mis = 1'b1;
        endcase
        mis = bus.req_valid & ((bus.req_read & load_mis) | (bus.req_write & store_mis));
    end

    assign access = bus.req_valid & (bus.req_read | bus.req_write) & ~mis;

    // state register and captured response word; reset drops any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                data_q <= bus.dmem_rdata;
            end
        end
    end

    // next state; the response word is captured only when the pipeline cannot take it now
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (bus.dmem_resp) begin
                        if (!bus.pipe_advance) begin
                            state_d = S_DONE;
                            capture = 1'b1;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.dmem_resp) begin
                    if (bus.pipe_advance) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        capture = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.pipe_advance) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // request is on the bus in IDLE/WAIT only; reset gates it off within the same cycle
    always_comb begin
        issue      = access & (state_q != S_DONE) & ~rst;
        in_done    = access & (state_q == S_DONE) & ~rst;
        load_valid = bus.req_read & ((issue & bus.dmem_resp) | in_done);
        word       = in_done ? data_q : bus.dmem_rdata;
    end

    // lane select by low address bits, then sign or zero extension by load type
    always_comb begin
        shifted = word >> {bus.req_addr[1:0], 3'b000};
        aligned = 32'd0;
        case (bus.req_funct3)
            3'b000:  aligned = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  aligned = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  aligned = word;
            3'b100:  aligned = {24'd0, shifted[7:0]};
            3'b101:  aligned = {16'd0, shifted[15:0]};
            default: aligned = 32'd0;
        endcase
    end

    assign bus.dmem_read        = issue & bus.req_read;
    assign bus.dmem_write       = issue & bus.req_write;
    assign bus.dmem_address     = {bus.req_addr[31:2], 2'b00};
    assign bus.dmem_wdata       = bus.req_wdata;
    assign bus.dmem_byte_enable = bus.req_write ? bus.req_wmask : 4'b1111;
    assign bus.stall            = issue & ~bus.dmem_resp;
    assign bus.load_data        = load_valid ? aligned : 32'd0;
    assign bus.misaligned       = mis;

endmodule

// File: tb/tb_mem_stage_dport.sv
// tb/tb_mem_stage_dport.sv - directed self-checking bench for mem_stage_dport
module tb_mem_stage_dport;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_stage_dport_if bus();

    mem_stage_dport dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wm);
        bus.req_valid  = 1'b1;
        bus.req_read   = rd;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_wmask  = wm;
    endtask

    task automatic clear_req();
        bus.req_valid    = 1'b0;
        bus.req_read     = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.req_wmask    = 4'b0000;
        bus.pipe_advance = 1'b0;
        bus.dmem_resp    = 1'b0;
        bus.dmem_rdata   = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // runs the current request with the response arriving delay cycles after issue;
    // pipeline advances on the response cycle; counts request/stall cycles
    task automatic run_access(input int delay, input logic [31:0] rdata,
                              output int nrd, output int nwr, output int nst,
                              output logic [31:0] ld);
        nrd = 0;
        nwr = 0;
        nst = 0;
        ld  = 32'hx;
        for (int c = 0; c <= delay; c++) begin
            bus.dmem_resp    = (c == delay);
            bus.dmem_rdata   = (c == delay) ? rdata : 32'h0BAD_0BAD;
            bus.pipe_advance = (c == delay);
            #1;
            nrd += int'(bus.dmem_read);
            nwr += int'(bus.dmem_write);
            nst += int'(bus.stall);
            if (c == delay) ld = bus.load_data;
            next_cycle();
        end
        clear_req();
    endtask

    int          nrd;
    int          nwr;
    int          nst;
    logic [31:0] ld;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_req();
        set_req(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'd0, 4'b0000);
        #2;
        check("rst_read",  32'(bus.dmem_read), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_ld",    bus.load_data, 32'd0);
        next_cycle();
        rst = 1'b0;
        #1;

        // LW, response 3 cycles after issue
        check("lw_addr", bus.dmem_address, 32'h0000_1004);
        check("lw_be",   32'(bus.dmem_byte_enable), 32'hF);
        run_access(3, 32'hDEAD_BEEF, nrd, nwr, nst, ld);
        check("lw_nread",  nrd, 4);
        check("lw_nstall", nst, 3);
        check("lw_ld",     ld, 32'hDEAD_BEEF);

        // sub-word loads with same-cycle response
        set_req(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 4'b0000);
        run_access(0, 32'h80FF_0000, nrd, nwr, nst, ld);
        check("lb_ld", ld, 32'hFFFF_FF80);
        check("lb_nstall", nst, 0);
        set_req(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 4'b0000);
        run_access(0, 32'h80FF_0000, nrd, nwr, nst, ld);
        check("lbu_ld", ld, 32'h0000_0080);
        set_req(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 4'b0000);
        run_access(0, 32'h8001_1234, nrd, nwr, nst, ld);
        check("lh_ld", ld, 32'hFFFF_8001);
        set_req(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'd0, 4'b0000);
        run_access(1, 32'h8001_1234, nrd, nwr, nst, ld);
        check("lhu_ld", ld, 32'h0000_8001);
        set_req(1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'd0, 4'b0000);
        run_access(0, 32'h0000_7F00, nrd, nwr, nst, ld);
        check("lb_pos_ld", ld, 32'h0000_007F);

        // SW with upper-half mask, response after 2 cycles
        set_req(1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'hABCD_0000, 4'b1100);
        #1;
        check("sw_be",    32'(bus.dmem_byte_enable), 32'hC);
        check("sw_addr",  bus.dmem_address, 32'h0000_0100);
        check("sw_wdata", bus.dmem_wdata, 32'hABCD_0000);
        run_access(2, 32'h1111_1111, nrd, nwr, nst, ld);
        check("sw_nwrite", nwr, 3);
        check("sw_nread",  nrd, 0);
        check("sw_nstall", nst, 2);
        check("sw_ld",     ld, 32'd0);

        // response while the pipeline is frozen: latched, never reissued
        set_req(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'd0, 4'b0000);
        #1;
        check("hold_stall0", 32'(bus.stall), 32'd1);
        next_cycle();
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'h1234_5678;
        #1;
        check("hold_resp_stall", 32'(bus.stall), 32'd0);
        check("hold_resp_ld",    bus.load_data, 32'h1234_5678);
        next_cycle();
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 32'h0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("hold_read",  32'(bus.dmem_read), 32'd0);
            check("hold_stall", 32'(bus.stall), 32'd0);
            check("hold_ld",    bus.load_data, 32'h1234_5678);
            bus.dmem_resp = 1'b1;
            next_cycle();
            bus.dmem_resp = 1'b0;
        end
        bus.pipe_advance = 1'b1;
        #1;
        check("hold_adv_ld", bus.load_data, 32'h1234_5678);
        next_cycle();
        set_req(1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'd0, 4'b0000);
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'h55AA_55AA;
        #1;
        check("back_idle_read", 32'(bus.dmem_read), 32'd1);
        check("back_idle_ld",   bus.load_data, 32'h55AA_55AA);
        next_cycle();
        clear_req();

        // misaligned accesses are suppressed
        set_req(1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'd0, 4'b0000);
        #1;
        check("mis_lw",       32'(bus.misaligned), 32'd1);
        check("mis_lw_read",  32'(bus.dmem_read), 32'd0);
        check("mis_lw_stall", 32'(bus.stall), 32'd0);
        set_req(1'b1, 1'b0, 3'b001, 32'h0000_0303, 32'd0, 4'b0000);
        #1;
        check("mis_lh", 32'(bus.misaligned), 32'd1);
        set_req(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'd0, 4'b0110);
        #1;
        check("mis_sw",       32'(bus.misaligned), 32'd1);
        check("mis_sw_write", 32'(bus.dmem_write), 32'd0);
        set_req(1'b1, 1'b0, 3'b000, 32'h0000_0303, 32'd0, 4'b0000);
        #1;
        check("ok_lb", 32'(bus.misaligned), 32'd0);
        clear_req();

        // stray response with no access is ignored
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        #1;
        check("stray_ld",    bus.load_data, 32'd0);
        check("stray_stall", 32'(bus.stall), 32'd0);
        next_cycle();
        clear_req();

        // async reset mid-WAIT, then the same request completes
        set_req(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 4'b0000);
        next_cycle();
        check("wait_stall", 32'(bus.stall), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_read",  32'(bus.dmem_read), 32'd0);
        check("arst_stall", 32'(bus.stall), 32'd0);
        check("arst_ld",    bus.load_data, 32'd0);
        next_cycle();
        rst = 1'b0;
        run_access(1, 32'hCAFE_F00D, nrd, nwr, nst, ld);
        check("rerun_nread",  nrd, 2);
        check("rerun_nstall", nst, 1);
        check("rerun_ld",     ld, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_dport.md
Name: mem_stage_dport

Overview:
- Memory-stage data-port controller. It consumes the EX/MEM pipeline register outputs and performs the load/store handshake with the data cache.
- It holds the pipeline via stall until the cache responds.
- It aligns and sign/zero-extends load data for the MEM/WB register.
- It latches the response if the pipeline cannot advance in the response cycle, so no access is ever reissued.

Parameters:
- none; all datapaths are 32-bit rv32i_word, 5-bit register fields unused here.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  EX/MEM entry holds a live instruction
- req_read  in  1  entry is a load
- req_write  in  1  entry is a store; never high together with req_read
- req_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  store data, already lane-shifted upstream
- req_wmask  in  4  store byte mask, already lane-positioned upstream
- pipe_advance  in  1  global pipeline load this cycle (EX/MEM and MEM/WB registers capture)
- dmem_read  out  1  cache read request
- dmem_write  out  1  cache write request
- dmem_address  out  32  {req_addr[31:2], 2'b00}
- dmem_wdata  out  32  equals req_wdata
- dmem_byte_enable  out  4  req_wmask on write, 4'b1111 on read
- dmem_rdata  in  32  cache read word, valid with dmem_resp
- dmem_resp  in  1  single-cycle completion pulse
- stall  out  1  hold the whole pipeline
- load_data  out  32  aligned, extended load result
- misaligned  out  1  access violates natural alignment; access suppressed

Behaviour:
- State machine has three states: IDLE, WAIT, DONE. Reset forces IDLE asynchronously and clears data_q (32-bit latched raw word) to 0.
- access = req_valid & (req_read | req_write) & !misaligned.
- misaligned (combinational) is:
  - LW: addr[1:0] != 0
  - LH/LHU: addr[0]
  - store with wmask not in {0001, 0010, 0100, 1000, 0011, 1100, 1111}
- In IDLE and WAIT, dmem_read/dmem_write follow access & req_read/req_write combinationally; they are 0 in DONE and during reset.
- stall = access & (state != DONE) & !dmem_resp.
- A response in the same cycle as the request is legal and yields zero stall cycles.
- Transitions:
  - IDLE: access & !dmem_resp -> WAIT.
  - IDLE or WAIT with dmem_resp: if pipe_advance -> IDLE, else -> DONE, capturing dmem_rdata into data_q.
  - WAIT without resp: stay.
  - DONE & pipe_advance -> IDLE; otherwise stay.
- load_data uses word = dmem_rdata on the response cycle, data_q in DONE.
  - Select lane by req_addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - For stores, non-accesses, and all other cycles, load_data = 0.
- Upstream guarantee: req_* stay stable while stall = 1 (EX/MEM not loaded). The block never asserts stall in DONE.
- dmem_resp outside a request (IDLE with no access, or DONE) is ignored.
- Async rst mid-WAIT drops dmem_read/dmem_write in the same cycle; the next access restarts from IDLE.
- Misaligned or non-memory instructions pass with stall = 0 and no cache request.

Test Plan:
- LW addr 0x0000_1004, resp after 3 cycles with rdata 0xDEADBEEF -> dmem_read high 4 cycles; stall high 3 cycles, low on the resp cycle; load_data = 0xDEADBEEF; address 0x0000_1004.
- LB addr 0x...03, rdata 0x80FF_0000, and LBU at the same address -> load_data 0xFFFF_FF80 and 0x0000_0080 respectively. LH addr 0x...02 with rdata 0x8001_1234 -> 0xFFFF_8001.
- SW, wmask 1100, wdata 0xAB_CD00_00 at addr 0x...02, resp after 2 cycles -> dmem_write for 3 cycles, byte_enable 1100, stall 2 cycles, load_data 0.
- LW with resp on a cycle where pipe_advance = 0 for 2 more cycles -> state DONE; no dmem_read reissued; load_data holds the captured word; stall 0; returns to IDLE on pipe_advance.
- LW at addr 0x...01 -> misaligned = 1, dmem_read = 0, stall = 0. Same-cycle resp LW -> zero stall.
- rst asserted mid-WAIT -> dmem_read drops immediately, stall 0, load_data 0. After release, the same request reissues and completes normally.
